// File: rtl/pcileech_fifo_tx_arb_pkg.sv
// Shared definitions for the FIFO->COM transmit arbiter: COM source ids and FSM states.
package pcileech_fifo_tx_arb_pkg;

    localparam int unsigned TXARB_SRC_TLP  = 0;
    localparam int unsigned TXARB_SRC_CFG  = 1;
    localparam int unsigned TXARB_SRC_CORE = 2;

    typedef enum logic [1:0] {
        TXARB_IDLE,
        TXARB_XFER,
        TXARB_DRAIN
    } txarb_state_t;

endpackage

// File: rtl/pcileech_skid_reg.sv
// Two-entry valid/ready skid buffer; in_ready is registered so out_ready never
// reaches the upstream side combinationally.
module pcileech_skid_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            // Skid entry, when present, always goes out first; in_ready was low so no new word arrives.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/pcileech_fifo_tx_arb.sv
// Packet-granular round-robin arbiter feeding the single 32-bit COM transmit path,
// with per-source enable, an over-length watchdog and a registered skid output stage.
module pcileech_fifo_tx_arb
    import pcileech_fifo_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_en,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*32-1:0]      src_data,
    input  logic [NUM_SRC-1:0]         src_last,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    output logic                       out_last,
    output logic [$clog2(NUM_SRC)-1:0] out_src,
    input  logic                       out_ready,
    output logic [NUM_SRC-1:0]         err_overlong
);

    localparam int unsigned SW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(MAX_WORDS + 1);
    localparam int unsigned W  = 32 + 1 + SW;

    txarb_state_t      state;
    logic [SW-1:0]     gnt;
    logic [SW-1:0]     rr_ptr;
    logic [CW-1:0]     cnt;
    logic [NUM_SRC-1:0] cand;
    logic              cur_valid;
    logic              cur_last;
    logic [31:0]       cur_data;
    logic              acc;
    logic              wd_hit;
    logic              skid_in_valid;
    logic              skid_ready;
    logic [W-1:0]      skid_in;
    logic [W-1:0]      skid_out;

    // Rotate so the source after ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] c, input logic [SW-1:0] ptr);
        logic [2*NUM_SRC-1:0] dbl;
        logic [NUM_SRC-1:0]   rot;
        int unsigned          sh;
        int unsigned          win;
        logic                 found;
        sh = int'(ptr) + 1;
        if (sh >= NUM_SRC) sh = 0;
        dbl   = {c, c} >> sh;
        rot   = dbl[NUM_SRC-1:0];
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && rot[k]) begin
                win   = k;
                found = 1'b1;
            end
        end
        return SW'((win + sh) % NUM_SRC);
    endfunction

    assign cand = src_valid & src_en;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        src_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gnt == SW'(i)) begin
                cur_valid = src_valid[i];
                cur_last  = src_last[i];
                cur_data  = src_data[32*i +: 32];
                if (state == TXARB_XFER)  src_ready[i] = skid_ready;
                if (state == TXARB_DRAIN) src_ready[i] = 1'b1;
            end
        end
    end

    assign acc           = cur_valid & (|src_ready);
    assign wd_hit        = (cnt == CW'(MAX_WORDS - 1)) & ~cur_last;
    assign skid_in_valid = (state == TXARB_XFER) & cur_valid;
    assign skid_in       = {gnt, cur_last | wd_hit, cur_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TXARB_IDLE;
            gnt          <= '0;
            rr_ptr       <= SW'(NUM_SRC - 1);
            cnt          <= '0;
            err_overlong <= '0;
        end else begin
            case (state)
                TXARB_IDLE: begin
                    if (|cand) begin
                        gnt   <= rr_pick(cand, rr_ptr);
                        state <= TXARB_XFER;
                    end
                end
                TXARB_XFER: begin
                    if (acc) begin
                        if (cur_last) begin
                            rr_ptr <= gnt;
                            cnt    <= '0;
                            state  <= TXARB_IDLE;
                        end else if (wd_hit) begin
                            err_overlong[gnt] <= 1'b1;
                            state             <= TXARB_DRAIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                TXARB_DRAIN: begin
                    if (acc && cur_last) begin
                        rr_ptr <= gnt;
                        cnt    <= '0;
                        state  <= TXARB_IDLE;
                    end
                end
                default: state <= TXARB_IDLE;
            endcase
        end
    end

    pcileech_skid_reg #(.W(W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (skid_in_valid),
        .in_data   (skid_in),
        .in_ready  (skid_ready),
        .out_valid (out_valid),
        .out_data  (skid_out),
        .out_ready (out_ready)
    );

    assign out_data = skid_out[31:0];
    assign out_last = skid_out[32];
    assign out_src  = skid_out[W-1:33];

endmodule

// File: tb/tb_pcileech_fifo_tx_arb.sv
// Scoreboard bench: a packet-level round-robin model fills the expected queue, a monitor checks output words.
module tb_pcileech_fifo_tx_arb;

    localparam int NSRC = 3;
    localparam int MAXW = 8;

    typedef struct packed {logic [31:0] data; logic last; logic mid;} word_t;
    typedef struct packed {logic [1:0] src; logic last; logic [31:0] data;} exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NSRC-1:0]   src_en = '0;
    logic [NSRC-1:0]   src_valid = '0;
    logic [NSRC*32-1:0] src_data = '0;
    logic [NSRC-1:0]   src_last = '0;
    logic [NSRC-1:0]   src_ready;
    logic              out_valid;
    logic [31:0]       out_data;
    logic              out_last;
    logic [1:0]        out_src;
    logic              out_ready = 1'b0;
    logic [NSRC-1:0]   err_overlong;

    word_t srcq [NSRC][$];
    int    plen [NSRC][$];
    exp_t  expq [$];
    logic  ready_pat [$];
    int    stall_pct = 0;
    int    bubble_pct = 0;
    int    checks = 0;
    int    errors = 0;
    logic [NSRC-1:0] fire = '0;

    pcileech_fifo_tx_arb #(.NUM_SRC(NSRC), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_en       (src_en),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .err_overlong (err_overlong)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source and sink driver: inputs change at negedge; handshakes latched #1 later.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NSRC; i++)
            if (fire[i] && rst_n && srcq[i].size() > 0) void'(srcq[i].pop_front());
        fire = '0;
        if (!rst_n) begin
            src_valid = '0;
            out_ready = 1'b0;
            continue;
        end
        for (int i = 0; i < NSRC; i++) begin
            src_valid[i] = 1'b0;
            if (srcq[i].size() > 0) begin
                if (!(srcq[i][0].mid && $urandom_range(0, 99) < bubble_pct)) begin
                    src_valid[i] = 1'b1;
                    src_data[32*i +: 32] = srcq[i][0].data;
                    src_last[i] = srcq[i][0].last;
                end
            end
        end
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
        #1;
        if (rst_n) fire = src_valid & src_ready;
    end

    // Monitor: compares every accepted output word and checks stall stability.
    initial begin
        exp_t e;
        exp_t got;
        exp_t prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            got = {out_src, out_last, out_data};
            if (prev_stall) check("stall_hold", {out_valid, got}, {1'b1, prev});
            prev_stall = out_valid && !out_ready;
            prev = got;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", got);
                end else begin
                    e = expq.pop_front();
                    check("out_word", got, e);
                end
            end
        end
    end

    task automatic add_pkt(input int s, input int len);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.data = $urandom;
            w.last = (k == len - 1);
            w.mid  = (k != 0);
            srcq[s].push_back(w);
        end
        plen[s].push_back(len);
    endtask

    // Reference: packet-level round robin over enabled sources with queued packets.
    task automatic build_expected(input logic [NSRC-1:0] en, input int max_pkts, output logic [NSRC-1:0] err);
        int idx[NSRC];
        int pk[NSRC];
        int ptr;
        int n;
        int s;
        int len;
        exp_t e;
        err = '0;
        ptr = NSRC - 1;
        n = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx[i] = 0;
            pk[i] = 0;
        end
        while (1) begin
            if (max_pkts > 0 && n >= max_pkts) break;
            s = -1;
            for (int k = 1; k <= NSRC; k++) begin
                int c;
                c = (ptr + k) % NSRC;
                if (s < 0 && en[c] && pk[c] < plen[c].size()) s = c;
            end
            if (s < 0) break;
            len = plen[s][pk[s]];
            for (int k = 0; k < len && k < MAXW; k++) begin
                e.src  = 2'(s);
                e.data = srcq[s][idx[s] + k].data;
                e.last = (k == len - 1) || (k == MAXW - 1);
                expq.push_back(e);
            end
            if (len > MAXW) err[s] = 1'b1;
            idx[s] += len;
            pk[s]++;
            ptr = s;
            n++;
        end
    endtask

    task automatic start_phase(input logic [NSRC-1:0] en, input int max_pkts, input int stall,
                               input int bubble, output logic [NSRC-1:0] experr);
        stall_pct = stall;
        bubble_pct = bubble;
        build_expected(en, max_pkts, experr);
        src_en = en;
    endtask

    task automatic finish_phase(input string name, input logic [NSRC-1:0] experr);
        int c;
        c = 0;
        while (expq.size() > 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_drained"}, 64'(expq.size()), 0);
        repeat (20) @(negedge clk);
        #3;
        check({name, "_idle"}, 64'(out_valid), 0);
        check({name, "_err"}, 64'(err_overlong), 64'(experr));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check(name, {out_valid, out_last, out_src, out_data, src_ready, err_overlong}, 0);
        for (int i = 0; i < NSRC; i++) begin
            srcq[i].delete();
            plen[i].delete();
        end
        expq.delete();
        ready_pat.delete();
        src_en = '0;
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [NSRC-1:0] ee;
        int c;
        #2;
        do_reset("reset_state");

        // Single-word packets from everyone: strict 0,1,2,0,1,2 rotation.
        for (int r = 0; r < 2; r++) for (int s = 0; s < NSRC; s++) add_pkt(s, 1);
        start_phase(3'b111, 0, 0, 0, ee);
        finish_phase("rr_single", ee);

        // Multi-word src0 packet is not interleaved with waiting src1.
        do_reset("reset_state2");
        add_pkt(0, 4);
        add_pkt(1, 1);
        start_phase(3'b111, 0, 0, 0, ee);
        finish_phase("no_interleave", ee);

        // Backpressure during an 8-word packet.
        do_reset("reset_state3");
        add_pkt(0, 8);
        for (int k = 0; k < 3; k++) ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b0);
        ready_pat.push_back(1'b0);
        ready_pat.push_back(1'b1);
        start_phase(3'b111, 0, 0, 0, ee);
        finish_phase("backpressure", ee);

        // Watchdog: src2 overlong packet truncated, next grant src0.
        do_reset("reset_state4");
        add_pkt(0, 1);
        add_pkt(0, 1);
        add_pkt(1, 1);
        add_pkt(1, 1);
        add_pkt(2, MAXW + 2);
        start_phase(3'b111, 0, 20, 0, ee);
        finish_phase("watchdog", ee);

        // Enable masking and mid-packet disable.
        do_reset("reset_state5");
        add_pkt(0, 2);
        add_pkt(1, 3);
        add_pkt(1, 2);
        add_pkt(2, 2);
        start_phase(3'b010, 1, 0, 0, ee);
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            #2;
            if (src_valid[1] && src_ready[1]) break;
            c++;
        end
        check("en_first_accept_seen", 64'(c < 200), 1);
        @(negedge clk);
        src_en = 3'b000;
        finish_phase("en_mask", ee);

        // Asynchronous reset mid-packet.
        do_reset("reset_state6");
        add_pkt(0, 6);
        start_phase(3'b111, 0, 0, 0, ee);
        c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("pre_reset_out_valid", 64'(out_valid), 1);
        @(posedge clk);
        #3;
        do_reset("async_reset");
        add_pkt(1, 1);
        add_pkt(0, 1);
        add_pkt(2, 1);
        start_phase(3'b111, 0, 0, 0, ee);
        finish_phase("post_reset_src0_first", ee);

        // Randomized traffic with stalls, mid-packet bubbles and random enables.
        for (int r = 0; r < 8; r++) begin
            do_reset("reset_rand");
            for (int s = 0; s < NSRC; s++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, MAXW + 3));
            end
            start_phase(3'($urandom_range(1, 7)), 0, 30, 25, ee);
            finish_phase("random", ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
